exposure_ctrl: RTL and testbench
================================

Name: exposure_ctrl

Overview:
- Camera control state machine sitting directly upstream of the exposure timer; drives timer Start/Initial and consumes its TF (terminal flag) as Timer_done.
- Holds the user-adjustable exposure time, sequences Erase -> Expose -> two-row readout, and generates the pixel-array and ADC control strobes.
- One instance per sensor; all logic on a single clock domain.

Parameters:
- W, 5, width of exposure-time register and Timer_init.
- EXP_MIN, 2, lowest exposure value (timer cycles).
- EXP_MAX, 30, highest exposure value.
- EXP_DEFAULT, 15, exposure value after reset.

Ports:
- Clk  in  1  clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- Init  in  1  level; request a capture, sampled only in IDLE.
- Exp_increase  in  1  button; rising edge increments exposure.
- Exp_decrease  in  1  button; rising edge decrements exposure.
- Timer_done  in  1  TF from exposure timer.
- Timer_start  out  1  one-cycle start pulse to timer.
- Timer_init  out  W  exposure value to timer (= exp_time register, continuously).
- Erase  out  1  pixel erase, high in IDLE.
- Expose  out  1  pixel expose.
- NRE_1  out  1  row-1 read enable, active-low.
- NRE_2  out  1  row-2 read enable, active-low.
- ADC  out  1  ADC convert strobe.
- Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous and active-high on Clk; it overrides everything, including mid-capture.
- Reset values: state=IDLE, exp_time=EXP_DEFAULT, Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Timer_start=0, Busy=0, edge-detect registers=0.
- All outputs are registered/decoded from state; no combinational path from any input to any output.
- States: IDLE, EXP_START, EXP_WAIT, READOUT.
- IDLE:
  - Erase=1.
  - If Init=1 at edge k -> EXP_START at k+1.
  - Init takes priority over adjustment: edges seen in the same cycle are discarded, but the edge-detect registers still update.
- EXP_START (1 cycle):
  - Timer_start=1, Expose=1, Erase=0.
  - Timer_done is ignored (stale flag).
  - -> EXP_WAIT.
- EXP_WAIT:
  - Expose=1.
  - On first cycle Timer_done=1 -> READOUT next cycle.
  - No timeout.
  - Init, Exp_increase and Exp_decrease are ignored.
- READOUT: 8 cycles, tracked by a 3-bit step counter cleared on entry.
  - step0: NRE_1=0.
  - step1: NRE_1=0, ADC=1.
  - step2: NRE_1=0.
  - step3: NRE_1=1, NRE_2=1.
  - step4: NRE_2=0.
  - step5: NRE_2=0, ADC=1.
  - step6: NRE_2=0.
  - step7: all high.
  - After step7 -> IDLE.
  - Expose=0 and Erase=0 throughout.
  - NRE_1 and NRE_2 are never low simultaneously.
- Exposure adjustment:
  - Only in IDLE.
  - Rising edge detected as btn & ~btn_q; btn_q is registered every cycle in all states.
  - Increment saturates at EXP_MAX; decrement saturates at EXP_MIN.
  - Both rising edges in the same cycle -> no change.
  - A held button yields exactly one step.
  - Edges occurring outside IDLE are lost; they are not queued.
- Timer_init changes only in IDLE, so it is stable from EXP_START to the end of READOUT.
- Capture latency: Init at edge k -> Timer_start at k+1. Timer_done at edge j -> READOUT step0 at j+1 -> IDLE at j+9.
- Init held high continuously -> back-to-back captures, re-entering EXP_START the cycle after returning to IDLE.
- Arithmetic:
  - Unsigned, W bits.
  - The saturation compare happens before add/subtract, so no wrap-around is possible.

Test Plan:
- Reset, then idle 5 cycles -> Erase=1, NRE_1=NRE_2=1, ADC=0, Expose=0, Busy=0, Timer_init=15.
- 20 separate Exp_increase pulses from 15 -> Timer_init stops at 30. 40 Exp_decrease pulses -> stops at 2. One pulse held 10 cycles -> exactly +1. Both buttons rising together -> unchanged.
- Init pulse at cycle 10, timer model with Initial=15 returning TF 15 cycles after Start:
  - Timer_start high only at cycle 11.
  - Expose high cycles 11 to TF+0.
  - READOUT at TF+1 with ADC high at TF+2 and TF+6.
  - Busy low and Erase high at TF+9.
- Reset asserted in EXP_WAIT and again at READOUT step4 -> next cycle all outputs at reset values and Timer_init=15. A prior adjustment to 20 is lost.
- Init held high 60 cycles, TF after 5 cycles -> two or more full captures, each with exactly one Timer_start and two ADC pulses. Exp_increase toggled during capture -> Timer_init unchanged.
- Timer_done held high from before Init -> ignored in EXP_START, READOUT begins at EXP_START+2.

Source files
------------

// File: rtl/exposure_ctrl.sv
// Camera capture sequencer: holds the exposure setting, runs erase -> expose -> two-row
// readout around an external exposure timer, and decodes pixel/ADC strobes from state.
module exposure_ctrl #(
  parameter int W           = 5,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 15
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Init,
  input  logic         Exp_increase,
  input  logic         Exp_decrease,
  input  logic         Timer_done,
  output logic         Timer_start,
  output logic [W-1:0] Timer_init,
  output logic         Erase,
  output logic         Expose,
  output logic         NRE_1,
  output logic         NRE_2,
  output logic         ADC,
  output logic         Busy
);

  localparam logic [W-1:0] EXP_MIN_V     = W'(EXP_MIN);
  localparam logic [W-1:0] EXP_MAX_V     = W'(EXP_MAX);
  localparam logic [W-1:0] EXP_DEFAULT_V = W'(EXP_DEFAULT);
  localparam logic [2:0]   LAST_STEP     = 3'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXP_START = 2'd1,
    EXP_WAIT  = 2'd2,
    READOUT   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [2:0]     r_step;
  logic [2:0]     w_step_next;
  logic [W-1:0]   r_exp_time;
  logic [W-1:0]   w_exp_time_next;
  logic [1:0]     w_btn;
  logic [1:0]     w_btn_rise;

  // Bit 0 = increase button, bit 1 = decrease button.
  assign w_btn = {Exp_decrease, Exp_increase};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn_edge
      logic r_btn_q;
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_btn_q <= 1'b0;
        end else begin
          r_btn_q <= w_btn[gi];
        end
      end
      assign w_btn_rise[gi] = w_btn[gi] & ~r_btn_q;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_step     <= 3'd0;
      r_exp_time <= EXP_DEFAULT_V;
    end else begin
      r_state    <= w_state_next;
      r_step     <= w_step_next;
      r_exp_time <= w_exp_time_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_step_next     = r_step;
    w_exp_time_next = r_exp_time;
    Timer_start     = 1'b0;
    Erase           = 1'b0;
    Expose          = 1'b0;
    NRE_1           = 1'b1;
    NRE_2           = 1'b1;
    ADC             = 1'b0;
    Busy            = 1'b1;

    case (r_state)
      IDLE: begin
        Erase = 1'b1;
        Busy  = 1'b0;
        if (Init) begin
          w_state_next = EXP_START;
        end else begin
          // Saturation is tested before stepping, so the register never wraps.
          case (w_btn_rise)
            2'b01: if (r_exp_time < EXP_MAX_V) w_exp_time_next = r_exp_time + W'(1);
            2'b10: if (r_exp_time > EXP_MIN_V) w_exp_time_next = r_exp_time - W'(1);
            default: w_exp_time_next = r_exp_time;
          endcase
        end
      end

      EXP_START: begin
        // Timer_done here is left over from the previous run; the timer reloads on this pulse.
        Timer_start  = 1'b1;
        Expose       = 1'b1;
        w_state_next = EXP_WAIT;
      end

      EXP_WAIT: begin
        Expose = 1'b1;
        if (Timer_done) begin
          w_state_next = READOUT;
          w_step_next  = 3'd0;
        end
      end

      READOUT: begin
        // Row 1 owns steps 0-2, row 2 owns steps 4-6; steps 3 and 7 are guard gaps.
        NRE_1       = (r_step > 3'd2);
        NRE_2       = !((r_step >= 3'd4) && (r_step <= 3'd6));
        ADC         = (r_step == 3'd1) || (r_step == 3'd5);
        w_step_next = r_step + 3'd1;
        if (r_step == LAST_STEP) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign Timer_init = r_exp_time;

endmodule

// File: tb/tb_exposure_ctrl.sv
// Scoreboard bench for exposure_ctrl: a cycle-level reference model queues the expected
// output vector each clock, and a monitor compares the DUT against it on the falling edge.
module tb_exposure_ctrl;

  localparam int W       = 5;
  localparam int EXP_MIN = 2;
  localparam int EXP_MAX = 30;
  localparam int EXP_DEF = 15;

  logic         Clk          = 1'b0;
  logic         Reset        = 1'b1;
  logic         Init         = 1'b0;
  logic         Exp_increase = 1'b0;
  logic         Exp_decrease = 1'b0;
  logic         Timer_done   = 1'b0;
  logic         Timer_start;
  logic [W-1:0] Timer_init;
  logic         Erase, Expose, NRE_1, NRE_2, ADC, Busy;

  int checks = 0;
  int passes = 0;

  // Vector layout: {Timer_start, Timer_init[4:0], Erase, Expose, NRE_1, NRE_2, ADC, Busy}
  logic [11:0] exp_q[$];

  int t_delay  = 15;
  bit td_force = 1'b0;

  exposure_ctrl #(
    .W(W), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX), .EXP_DEFAULT(EXP_DEF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Init(Init),
    .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
    .Timer_done(Timer_done), .Timer_start(Timer_start), .Timer_init(Timer_init),
    .Erase(Erase), .Expose(Expose), .NRE_1(NRE_1), .NRE_2(NRE_2),
    .ADC(ADC), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Exposure timer stand-in: reloads on Start, raises TF t_delay cycles later and holds it.
  initial begin : timer_model
    bit armed;
    int cnt;
    armed = 1'b0;
    cnt   = 0;
    forever begin
      @(negedge Clk);
      if (Timer_start) begin
        armed = 1'b1;
        cnt   = t_delay;
      end else if (armed && cnt > 0) begin
        cnt--;
      end
      Timer_done = td_force || (armed && cnt == 0 && !Timer_start);
    end
  end

  // Reference model: capture phase plus a position within the 8-cycle readout pattern.
  initial begin : ref_model
    logic [2:0] ro_tab [0:7];   // {NRE_1, NRE_2, ADC} for each readout cycle
    int  phase;                 // 0 idle, 1 start, 2 waiting, 3 readout
    int  ro_pos;
    int  exp_time;
    int  captures;
    bit  inc_prev, dec_prev, inc_rise, dec_rise;
    logic [4:0] t5;
    ro_tab[0] = 3'b010; ro_tab[1] = 3'b011; ro_tab[2] = 3'b010; ro_tab[3] = 3'b110;
    ro_tab[4] = 3'b100; ro_tab[5] = 3'b101; ro_tab[6] = 3'b100; ro_tab[7] = 3'b110;
    phase = 0; ro_pos = 0; exp_time = EXP_DEF; captures = 0;
    inc_prev = 1'b0; dec_prev = 1'b0;
    forever begin
      @(posedge Clk);
      inc_rise = Exp_increase && !inc_prev;
      dec_rise = Exp_decrease && !dec_prev;
      if (Reset) begin
        phase = 0; ro_pos = 0; exp_time = EXP_DEF;
        inc_prev = 1'b0; dec_prev = 1'b0;
      end else begin
        if (phase == 0) begin
          if (Init) phase = 1;
          else if (inc_rise && !dec_rise) exp_time = (exp_time + 1 > EXP_MAX) ? EXP_MAX : exp_time + 1;
          else if (dec_rise && !inc_rise) exp_time = (exp_time - 1 < EXP_MIN) ? EXP_MIN : exp_time - 1;
        end else if (phase == 1) begin
          phase = 2;
        end else if (phase == 2) begin
          if (Timer_done) begin phase = 3; ro_pos = 0; end
        end else begin
          if (ro_pos == 7) begin
            phase = 0;
            captures++;
            $display("capture %0d complete, exposure %0d", captures, exp_time);
          end else begin
            ro_pos++;
          end
        end
        inc_prev = Exp_increase;
        dec_prev = Exp_decrease;
      end
      t5 = 5'(exp_time);
      case (phase)
        0:       exp_q.push_back({1'b0, t5, 1'b1, 1'b0, 3'b110, 1'b0});
        1:       exp_q.push_back({1'b1, t5, 1'b0, 1'b1, 3'b110, 1'b1});
        2:       exp_q.push_back({1'b0, t5, 1'b0, 1'b1, 3'b110, 1'b1});
        default: exp_q.push_back({1'b0, t5, 1'b0, 1'b0, ro_tab[ro_pos], 1'b1});
      endcase
    end
  end

  initial begin : monitor
    logic [11:0] want, got;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {Timer_start, Timer_init, Erase, Expose, NRE_1, NRE_2, ADC, Busy};
        checks++;
        if (got === want) passes++;
        else $display("FAIL outputs t=%0t got %b expected %b (start,init,erase,expose,nre1,nre2,adc,busy)",
                      $time, got, want);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_btn(input bit inc, input int n);
    repeat (n) begin
      if (inc) Exp_increase = 1'b1; else Exp_decrease = 1'b1;
      step(1);
      Exp_increase = 1'b0;
      Exp_decrease = 1'b0;
      step(1);
    end
  endtask

  task automatic start_capture();
    Init = 1'b1;
    step(1);
    Init = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (Busy === 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (Busy === 1'b0) passes++;
    else $display("FAIL idle_timeout Busy=%b after %0d cycles, required 0", Busy, n);
  endtask

  initial begin : stimulus
    int n;
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(5);

    pulse_btn(1'b1, 20);
    pulse_btn(1'b0, 40);
    Exp_increase = 1'b1;
    step(10);
    Exp_increase = 1'b0;
    step(2);
    Exp_increase = 1'b1;
    Exp_decrease = 1'b1;
    step(1);
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    step(2);

    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    step(9);
    t_delay = 15;
    start_capture();
    wait_idle(60);
    step(3);

    // Adjust to 20, then reset while exposing.
    pulse_btn(1'b1, 5);
    start_capture();
    step(4);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    step(3);

    // Adjust to 20, then reset on the first row-2 readout cycle.
    pulse_btn(1'b1, 5);
    t_delay = 6;
    start_capture();
    n = 0;
    while (NRE_2 !== 1'b0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (NRE_2 === 1'b0) passes++;
    else $display("FAIL row2_wait NRE_2=%b after %0d cycles, required 0", NRE_2, n);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    step(3);

    // Back-to-back captures with the increase button toggling throughout.
    t_delay = 5;
    Init = 1'b1;
    repeat (60) begin
      Exp_increase = 1'($urandom_range(0, 1));
      step(1);
    end
    Init = 1'b0;
    Exp_increase = 1'b0;
    wait_idle(40);
    step(2);

    // Stale TF held high before the capture starts.
    td_force = 1'b1;
    step(2);
    start_capture();
    wait_idle(40);
    td_force = 1'b0;
    step(2);

    repeat (400) begin
      t_delay      = $urandom_range(1, 12);
      Init         = ($urandom_range(0, 15) == 0);
      Exp_increase = ($urandom_range(0, 2) == 0);
      Exp_decrease = ($urandom_range(0, 2) == 0);
      Reset        = ($urandom_range(0, 199) == 0);
      step(1);
    end
    Init = 1'b0;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    Reset = 1'b0;
    wait_idle(40);
    step(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
